// File: rtl/exec_stage_pipelined.sv
// Execute stage: single-cycle ALU ops plus a WIDTH-step shift-add multiplier,
// feeding one output register with a valid/ready handshake and {C,N,Z} flags.
//
//   state    | meaning
//   IDLE     | ready for a new operation (if the output register can take it)
//   MUL_BUSY | shift-add multiply in progress, or finished and awaiting output slot
module exec_stage_pipelined #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] immediate,
    input  logic             alu_src,
    input  logic [2:0]       alu_op,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [2:0]       ccr
);

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   b_sel;
    logic               out_free;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic               mul_load;
    logic               single_load;
    logic               load;

    logic [SHW:0]       mul_cnt;
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0]   mul_b;
    logic [WIDTH-1:0]   mul_bsel;
    logic               mul_rd;
    logic               mul_wr;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_pass;

    logic [WIDTH-1:0]   ld_res;
    logic [WIDTH-1:0]   ld_addr;
    logic               ld_c;
    logic               ld_keep;
    logic               ld_rd;
    logic               ld_wr;
    logic [2:0]         ld_ccr;

    assign b_sel       = alu_src ? immediate : op2;
    assign out_free    = !out_valid || out_ready;
    // in_ready is held low while reset is asserted
    assign in_ready    = rst_n && (state == IDLE) && out_free;
    assign accept      = in_valid && in_ready && !flush;
    assign mul_start   = accept && (alu_op == OP_MUL);
    assign single_load = accept && (alu_op != OP_MUL);
    assign mul_done    = (state == MUL_BUSY) && (mul_cnt == CNT_LAST);
    assign mul_load    = mul_done && out_free && !flush;
    assign load        = single_load || mul_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    state_nxt = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (flush || mul_load) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum      = {1'b0, op1} + {1'b0, b_sel};
        // bit WIDTH of the extended shift is the last bit pushed out of the word
        shl_ext  = {1'b0, op1} << b_sel[SHW-1:0];
        alu_res  = '0;
        alu_c    = ccr[2];
        alu_pass = 1'b0;
        case (alu_op)
            OP_PASS: begin
                alu_res  = b_sel;
                alu_pass = 1'b1;
            end
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = op1 - b_sel;
                alu_c   = (op1 < b_sel);
            end
            OP_AND: alu_res = op1 & b_sel;
            OP_OR:  alu_res = op1 | b_sel;
            OP_NOT: alu_res = ~op1;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    always_comb begin
        ld_res  = alu_res;
        ld_c    = alu_c;
        ld_keep = alu_pass;
        ld_addr = b_sel;
        ld_rd   = mem_read;
        ld_wr   = mem_write;
        if (mul_load) begin
            ld_res  = mul_acc[WIDTH-1:0];
            ld_c    = |mul_acc[2*WIDTH-1:WIDTH];
            ld_keep = 1'b0;
            ld_addr = mul_bsel;
            ld_rd   = mul_rd;
            ld_wr   = mul_wr;
        end
        ld_ccr = ld_keep ? ccr : {ld_c, ld_res[WIDTH-1], (ld_res == '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt  <= '0;
            mul_a    <= '0;
            mul_acc  <= '0;
            mul_b    <= '0;
            mul_bsel <= '0;
            mul_rd   <= 1'b0;
            mul_wr   <= 1'b0;
        end else if (mul_start) begin
            mul_cnt  <= '0;
            mul_a    <= {{WIDTH{1'b0}}, op1};
            mul_acc  <= '0;
            mul_b    <= b_sel;
            mul_bsel <= b_sel;
            mul_rd   <= mem_read;
            mul_wr   <= mem_write;
        end else if (flush || mul_load) begin
            mul_cnt <= '0;
        end else if ((state == MUL_BUSY) && (mul_cnt != CNT_LAST)) begin
            if (mul_b[0]) begin
                mul_acc <= mul_acc + mul_a;
            end
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + 1'b1;
        end
    end

    // Output register: data only changes on a load, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            mem_addr    <= '0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            ccr         <= 3'b000;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            result      <= ld_res;
            mem_addr    <= ld_addr;
            mem_read_o  <= ld_rd;
            mem_write_o <= ld_wr;
            ccr         <= ld_ccr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_stage_pipelined.sv
// Scoreboard bench for exec_stage_pipelined (WIDTH=16): expected results are
// queued at accept and compared when the output handshake completes.
module tb_exec_stage_pipelined;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [2:0]  ccr;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b2;
        logic [15:0] imm;
        logic        src;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] immediate;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] mem_addr;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [2:0]  ccr;

    logic        ordy_dir;
    logic        ordy_rnd;
    logic        rnd_bp;
    assign out_ready = rnd_bp ? ordy_rnd : ordy_dir;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [2:0]  ccr_m;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic        seen;
    vec_t        vecs[10];

    always #5 clk = ~clk;

    exec_stage_pipelined #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op1        (op1),
        .op2        (op2),
        .immediate  (immediate),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .mem_addr   (mem_addr),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .ccr        (ccr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic rd, input logic wr, input logic [2:0] cin);
        exp_t        e;
        logic [15:0] r;
        logic        c;
        logic [16:0] s;
        logic [31:0] p;
        int          idx;
        r = '0;
        c = cin[2];
        case (op)
            3'd0: r = b;
            3'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            3'd2: begin r = a - b; c = (a < b); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = ~a;
            3'd6: begin
                r = a << b[3:0];
                if (b[3:0] == 4'd0) c = 1'b0;
                else begin idx = 16 - int'(b[3:0]); c = a[idx]; end
            end
            default: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; c = |p[31:16]; end
        endcase
        e.res  = r;
        e.addr = b;
        e.rd   = rd;
        e.wr   = wr;
        e.ccr  = (op == 3'd0) ? cin : {c, r[15], (r == 16'h0)};
        return e;
    endfunction

    task automatic push_exp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b2,
                            input logic [15:0] imm, input logic src, input logic rd, input logic wr);
        exp_t e;
        e = model(op, a, src ? imm : b2, rd, wr, ccr_m);
        ccr_m = e.ccr;
        sb_q.push_back(e);
    endtask

    // Called just after a falling edge; returns 1 time unit after the accept edge.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b2,
                        input logic [15:0] imm, input logic src, input logic rd, input logic wr,
                        input bit push);
        int waited = 0;
        alu_op = op; op1 = a; op2 = b2; immediate = imm; alu_src = src;
        mem_read = rd; mem_write = wr; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) push_exp(op, a, b2, imm, src, rd, wr);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_result", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("result", result, mon_e.res);
                check_val("mem_addr", mem_addr, mon_e.addr);
                check_val("mem_ctl", {mem_read_o, mem_write_o}, {mon_e.rd, mon_e.wr});
                check_val("ccr", ccr, mon_e.ccr);
            end
        end
    end

    always @(posedge clk) begin
        #1 ordy_rnd = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop;
        rst_n = 1'b1;
        in_valid = 0; op1 = 0; op2 = 0; immediate = 0; alu_src = 0; alu_op = 0;
        mem_read = 0; mem_write = 0; flush = 0; ordy_dir = 1; ordy_rnd = 1; rnd_bp = 0;
        ccr_m = 3'b000;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", result, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_ctl", {mem_read_o, mem_write_o}, 0);
        check_val("rst_ccr", ccr, 0);
        check_val("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("in_ready_after_rst", in_ready, 1);

        // ADD wrap: result 0, C=1 Z=1, latency 1
        send(3'd1, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);
        check_val("add_latency", out_valid, 1);

        // SUB with immediate: borrow, negative
        send(3'd2, 16'h0005, 16'h1234, 16'h0007, 1'b1, 1'b1, 1'b0, 1);
        @(negedge clk);

        vecs[0] = '{3'd3, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0};
        vecs[1] = '{3'd4, 16'h8000, 16'h0000, 16'h0001, 1'b1};
        vecs[2] = '{3'd5, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{3'd6, 16'h8001, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{3'd6, 16'h8001, 16'h0001, 16'h0000, 1'b0};
        vecs[5] = '{3'd6, 16'h0003, 16'h0000, 16'h000F, 1'b1};
        vecs[6] = '{3'd0, 16'h1111, 16'hABCD, 16'h0000, 1'b0};
        vecs[7] = '{3'd7, 16'h0003, 16'h0005, 16'h0000, 1'b0};
        vecs[8] = '{3'd7, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};
        vecs[9] = '{3'd6, 16'h4000, 16'h0012, 16'h0000, 1'b0};
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b2, vecs[i].imm, vecs[i].src, i[0], i[1], 1);
            @(negedge clk);
        end

        // MUL latency: 0x100*0x100 -> 0, C=1 Z=1, valid 17 cycles after accept
        send(3'd7, 16'h0100, 16'h0100, 16'h0, 1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16) check_val("mul_busy_in_ready", in_ready, 0);
            check_val("mul_early_valid", out_valid, 0);
        end
        @(negedge clk);
        check_val("mul_latency17", out_valid, 1);

        // Backpressure: result held, second op accepted on the drain cycle
        @(posedge clk); #1 ordy_dir = 1'b0;
        @(negedge clk);
        send(3'd1, 16'h1111, 16'h2222, 16'h0, 1'b0, 1'b0, 1'b0, 1);
        alu_op = 3'd2; op1 = 16'h0001; op2 = 16'h0002; alu_src = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("stall_result", result, 16'h3333);
            check_val("stall_ccr", ccr, 3'b000);
            check_val("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 ordy_dir = 1'b1;
        @(negedge clk);
        check_val("drain_in_ready", in_ready, 1);
        @(posedge clk);
        push_exp(3'd2, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b0, 1'b0);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_val("second_valid", out_valid, 1);

        // Flush on MUL busy cycle 5
        @(negedge clk);
        send(3'd7, 16'h0003, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check_val("flush_out_valid", out_valid, 0);
        check_val("flush_in_ready", in_ready, 1);
        check_val("flush_ccr", ccr, ccr_m);
        seen = 1'b0;
        repeat (25) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check_val("flush_no_result", seen, 0);

        // Flush beats a simultaneous accept
        alu_op = 3'd1; op1 = 16'h0007; op2 = 16'h0001; alu_src = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_val("flush_vs_accept", out_valid, 0);

        // Random ops with random backpressure
        @(posedge clk); #1 rnd_bp = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd7 && $urandom_range(0, 2) != 0) rop = 3'd1;
            send(rop, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
            @(negedge clk);
        end
        @(posedge clk); #1 rnd_bp = 1'b0;
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        check_val("random_drained", sb_q.size(), 0);

        // Async reset mid-MUL
        @(negedge clk);
        send(3'd4, 16'h00F0, 16'h0F00, 16'h0, 1'b0, 1'b1, 1'b1, 1);
        @(negedge clk);
        send(3'd7, 16'h1234, 16'h0005, 16'h0, 1'b0, 1'b1, 1'b0, 0);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #2;
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_result", result, 0);
        check_val("arst_mem_addr", mem_addr, 0);
        check_val("arst_mem_ctl", {mem_read_o, mem_write_o}, 0);
        check_val("arst_ccr", ccr, 0);
        check_val("arst_in_ready", in_ready, 0);
        #1 rst_n = 1'b1;
        ccr_m = 3'b000;
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        check_val("arst_no_result", seen, 0);

        send(3'd1, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clk);
        check_val("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
